// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: gates integrators per sample, pulses the comb chain
// once per R samples, hides warm-up outputs and hands results out via valid/ready.
//
// state  | meaning
// IDLE   | decimator stopped, phase held at 0, no enables
// WARMUP | comb history not yet valid, comb pulses are counted but not presented
// RUN    | each comb pulse yields a decimated output one cycle later
module cic_decim_ctrl #(
  parameter int N_STAGES = 3,
  parameter int RATIO_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [RATIO_W-1:0] ratio_i,
  input  logic               ratio_load_i,
  input  logic               in_valid_i,
  output logic               int_en_o,
  output logic               comb_en_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               overrun_o,
  output logic [RATIO_W-1:0] phase_o,
  output logic               busy_o
);

  localparam int WU_W = (N_STAGES < 2) ? 1 : $clog2(N_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [RATIO_W-1:0] phase, phase_nxt;
  logic [RATIO_W-1:0] r_active, r_active_nxt;
  logic [RATIO_W-1:0] r_shadow, r_shadow_nxt;
  logic [RATIO_W-1:0] ratio_sat;
  logic [WU_W-1:0]    wu_left, wu_left_nxt;
  logic               pending, pending_nxt;
  logic               out_valid, out_valid_nxt;
  logic               overrun, overrun_nxt;
  logic               int_en, comb_en, period_end;

  // A requested ratio of zero is treated as one.
  assign ratio_sat  = (ratio_i == '0) ? RATIO_W'(1) : ratio_i;
  assign period_end = (phase == (r_active - RATIO_W'(1)));
  assign int_en     = in_valid_i & (state != IDLE);
  assign comb_en    = int_en & period_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      r_active  <= RATIO_W'(1);
      r_shadow  <= RATIO_W'(1);
      wu_left   <= '0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      r_active  <= r_active_nxt;
      r_shadow  <= r_shadow_nxt;
      wu_left   <= wu_left_nxt;
      pending   <= pending_nxt;
      out_valid <= out_valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    r_active_nxt  = r_active;
    r_shadow_nxt  = r_shadow;
    wu_left_nxt   = wu_left;
    pending_nxt   = pending;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun;

    if (ratio_load_i) begin
      r_shadow_nxt = ratio_sat;
    end

    case (state)
      IDLE: begin
        // Start-up ratio comes straight from ratio_i, not from the shadow.
        if (enable_i) begin
          state_nxt     = WARMUP;
          r_active_nxt  = ratio_sat;
          phase_nxt     = '0;
          wu_left_nxt   = WU_W'(N_STAGES);
          pending_nxt   = 1'b0;
          out_valid_nxt = 1'b0;
          overrun_nxt   = 1'b0;
        end
      end

      default: begin
        if (int_en) begin
          phase_nxt = period_end ? '0 : phase + RATIO_W'(1);
        end

        // A new result takes priority over a same-cycle accept.
        if (comb_en && (state == RUN)) begin
          out_valid_nxt = 1'b1;
          if (out_valid && !out_ready_i) begin
            overrun_nxt = 1'b1;
          end
        end else if (out_valid && out_ready_i) begin
          out_valid_nxt = 1'b0;
        end

        if (comb_en && (state == WARMUP)) begin
          wu_left_nxt = wu_left - WU_W'(1);
          if (wu_left == WU_W'(1)) begin
            state_nxt = RUN;
          end
        end

        // A differing ratio invalidates the comb history, so warm up again.
        if (comb_en && pending) begin
          r_active_nxt = r_shadow;
          pending_nxt  = 1'b0;
          if (r_shadow != r_active) begin
            state_nxt   = WARMUP;
            wu_left_nxt = WU_W'(N_STAGES);
          end
        end

        if (ratio_load_i) begin
          pending_nxt = 1'b1;
        end

        if (!enable_i) begin
          state_nxt     = IDLE;
          phase_nxt     = '0;
          pending_nxt   = 1'b0;
          out_valid_nxt = 1'b0;
          overrun_nxt   = 1'b0;
        end
      end
    endcase
  end

  assign int_en_o    = int_en;
  assign comb_en_o   = comb_en;
  assign out_valid_o = out_valid;
  assign overrun_o   = overrun;
  assign phase_o     = phase;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_cic_decim_ctrl;

  localparam int NST = 3;

  logic       clk;
  logic       reset;
  logic       enable_i;
  logic [7:0] ratio_i;
  logic       ratio_load_i;
  logic       in_valid_i;
  logic       int_en_o;
  logic       comb_en_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       overrun_o;
  logic [7:0] phase_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;

  cic_decim_ctrl #(.N_STAGES(NST), .RATIO_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable_i),
    .ratio_i      (ratio_i),
    .ratio_load_i (ratio_load_i),
    .in_valid_i   (in_valid_i),
    .int_en_o     (int_en_o),
    .comb_en_o    (comb_en_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .overrun_o    (overrun_o),
    .phase_o      (phase_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endfunction

  function automatic int sat(int r);
    return (r == 0) ? 1 : r;
  endfunction

  // Behavioural model: mode 0 idle, 1 warming up, 2 running.
  int m_mode, m_phase, m_r, m_shadow, m_pulses;
  bit m_pend, m_ov, m_ovr, model_ok = 1'b0;

  always @(negedge clk) begin : model_cmp
    bit e_int, e_comb, emit;
    logic [12:0] act, expv;
    e_int  = in_valid_i && (m_mode != 0);
    e_comb = e_int && (m_phase == m_r - 1);
    if (model_ok) begin
      act  = {int_en_o, comb_en_o, out_valid_o, overrun_o, busy_o, phase_o};
      expv = {e_int, e_comb, m_ov, m_ovr, (m_mode != 0), 8'(m_phase)};
      chk("model_cycle", 32'(act), 32'(expv));
    end
    if (reset) begin
      m_mode = 0; m_phase = 0; m_r = 1; m_shadow = 1; m_pulses = 0;
      m_pend = 0; m_ov = 0; m_ovr = 0; model_ok = 1'b1;
    end else if (m_mode == 0) begin
      if (ratio_load_i) m_shadow = sat(int'(ratio_i));
      if (enable_i) begin
        m_mode = 1; m_r = sat(int'(ratio_i)); m_phase = 0; m_pulses = 0;
        m_pend = 0; m_ov = 0; m_ovr = 0;
      end
    end else if (!enable_i) begin
      m_mode = 0; m_phase = 0; m_pend = 0; m_ov = 0; m_ovr = 0;
      if (ratio_load_i) m_shadow = sat(int'(ratio_i));
    end else begin
      emit = e_comb && (m_mode == 2);
      if (e_comb) begin
        if (m_mode == 1) begin
          m_pulses++;
          if (m_pulses == NST) m_mode = 2;
        end
        if (m_pend) begin
          if (m_shadow != m_r) begin
            m_mode = 1;
            m_pulses = 0;
          end
          m_r = m_shadow;
          m_pend = 0;
        end
      end
      if (e_int) m_phase = e_comb ? 0 : m_phase + 1;
      if (emit) begin
        if (m_ov && !out_ready_i) m_ovr = 1;
        m_ov = 1;
      end else if (m_ov && out_ready_i) begin
        m_ov = 0;
      end
      if (ratio_load_i) begin
        m_shadow = sat(int'(ratio_i));
        m_pend = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; enable_i = 0; ratio_i = 0; ratio_load_i = 0;
    in_valid_i = 0; out_ready_i = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_outputs", 32'({int_en_o, comb_en_o, out_valid_o, overrun_o, busy_o, phase_o}), 0);
    cyc();

    // R=4, continuous samples, ready high
    reset = 0; enable_i = 1; ratio_i = 8'd4; out_ready_i = 1;
    cyc();
    in_valid_i = 1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("r4_comb", 32'(comb_en_o), 32'(j % 4 == 0));
      chk("r4_valid", 32'(out_valid_o), 32'(j == 17));
      if (j == 3) chk("r4_phase", 32'(phase_o), 2);
      cyc();
    end

    // Overrun with ready held low for two periods
    out_ready_i = 0;
    for (int j = 21; j <= 28; j++) begin
      @(negedge clk);
      chk("ovr_valid_held", 32'(out_valid_o), 1);
      cyc();
    end
    out_ready_i = 1;
    @(negedge clk);
    chk("ovr_set", 32'({out_valid_o, overrun_o}), 32'(2'b11));
    cyc();

    // Ratio change 4 -> 8 requested at phase 1
    ratio_i = 8'd8; ratio_load_i = 1;
    @(negedge clk);
    chk("ovr_sticky", 32'({out_valid_o, overrun_o}), 32'(2'b01));
    chk("load_phase", 32'(phase_o), 1);
    cyc();
    ratio_load_i = 0;
    for (int j = 31; j <= 65; j++) begin
      if (j == 64) out_ready_i = 0;
      @(negedge clk);
      chk("rc_comb", 32'(comb_en_o), 32'((j == 32) || (j > 32 && (j - 32) % 8 == 0)));
      chk("rc_valid", 32'(out_valid_o), 32'((j == 33) || (j == 65)));
      if (j == 37) chk("rc_phase", 32'(phase_o), 4);
      cyc();
    end

    // Disable mid-period with a pending output
    enable_i = 0;
    @(negedge clk);
    chk("dis_valid_before", 32'(out_valid_o), 1);
    cyc();
    ratio_i = 8'd0; enable_i = 1; out_ready_i = 1;
    @(negedge clk);
    chk("dis_idle", 32'({busy_o, out_valid_o, int_en_o, phase_o}), 0);
    cyc();

    // ratio_i = 0 on enable behaves as R=1
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("r1_comb", 32'(comb_en_o), 1);
      chk("r1_valid", 32'(out_valid_o), 32'(k >= 5));
      cyc();
    end

    // Sparse samples (1 in 3), R=4
    enable_i = 0;
    cyc();
    enable_i = 1; ratio_i = 8'd4; in_valid_i = 0;
    cyc();
    for (int c = 0; c < 36; c++) begin
      in_valid_i = (c % 3 == 0);
      @(negedge clk);
      chk("sparse_comb", 32'(comb_en_o), 32'(c == 9 || c == 21 || c == 33));
      cyc();
    end

    // Reset in the middle of operation
    in_valid_i = 1;
    repeat (6) cyc();
    reset = 1;
    cyc();
    @(negedge clk);
    chk("midrun_reset", 32'({int_en_o, comb_en_o, out_valid_o, overrun_o, busy_o, phase_o}), 0);
    cyc();
    reset = 0;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      enable_i     = ($urandom_range(0, 99) < 97);
      ratio_i      = 8'($urandom_range(0, 6));
      ratio_load_i = ($urandom_range(0, 19) == 0);
      in_valid_i   = ($urandom_range(0, 9) < 6);
      out_ready_i  = ($urandom_range(0, 1) == 1);
      cyc();
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
